// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand fetch sequencer and its bypass.
package operand_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Register 0 is hardwired to zero.
  localparam int unsigned ZERO_ADDR = 0;

endpackage

// File: rtl/operand_bypass.sv
// Combinational fetch value: zero register, same-edge write-back forwarding, else file data.
module operand_bypass
  import operand_fetch_pkg::*;
#(
  parameter int unsigned data_width = 32,
  parameter int unsigned addr_width = 5
) (
  input  logic [addr_width-1:0] addr_i,
  input  logic [data_width-1:0] rd_data_i,
  input  logic                  wb_en_i,
  input  logic [addr_width-1:0] wb_addr_i,
  input  logic [data_width-1:0] wb_data_i,
  output logic [data_width-1:0] fetch_o
);

  always_comb begin
    fetch_o = rd_data_i;
    if (addr_i == addr_width'(ZERO_ADDR)) begin
      fetch_o = '0;
    end else if (wb_en_i && (wb_addr_i == addr_i)) begin
      fetch_o = wb_data_i;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Read-side sequencer: fetches rs1 then optionally rs2 through one read port and
// holds both operands, kept coherent with write-backs, until the ALU consumes them.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned data_width = 32,
  parameter int unsigned addr_width = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [addr_width-1:0] req_rs1,
  input  logic [addr_width-1:0] req_rs2,
  input  logic                  req_use_rs2,
  output logic [addr_width-1:0] rd_addr,
  input  logic [data_width-1:0] rd_data,
  input  logic                  wb_en,
  input  logic [addr_width-1:0] wb_addr,
  input  logic [data_width-1:0] wb_data,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [data_width-1:0] op_a,
  output logic [data_width-1:0] op_b
);

  state_e                state_q;
  logic [addr_width-1:0] rs1_q;
  logic [addr_width-1:0] rs2_q;
  logic                  use_rs2_q;
  logic [data_width-1:0] op_a_q;
  logic [data_width-1:0] op_b_q;
  logic [data_width-1:0] fetched;
  logic                  hit_a;
  logic                  hit_b;

  // Read address is a pure decode of state and the latched request.
  always_comb begin
    rd_addr = addr_width'(ZERO_ADDR);
    case (state_q)
      READ_A:  rd_addr = rs1_q;
      READ_B:  rd_addr = rs2_q;
      default: rd_addr = addr_width'(ZERO_ADDR);
    endcase
  end

  operand_bypass #(
    .data_width(data_width),
    .addr_width(addr_width)
  ) u_bypass (
    .addr_i    (rd_addr),
    .rd_data_i (rd_data),
    .wb_en_i   (wb_en),
    .wb_addr_i (wb_addr),
    .wb_data_i (wb_data),
    .fetch_o   (fetched)
  );

  // Write-backs that land on a held operand while it waits for the ALU.
  assign hit_a = wb_en && (wb_addr == rs1_q) && (rs1_q != addr_width'(ZERO_ADDR));
  assign hit_b = wb_en && use_rs2_q && (wb_addr == rs2_q) &&
                 (rs2_q != addr_width'(ZERO_ADDR));

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      use_rs2_q <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            rs1_q     <= req_rs1;
            rs2_q     <= req_rs2;
            use_rs2_q <= req_use_rs2;
            state_q   <= READ_A;
          end
        end
        READ_A: begin
          op_a_q <= fetched;
          if (use_rs2_q) begin
            state_q <= READ_B;
          end else begin
            op_b_q  <= '0;
            state_q <= HOLD;
          end
        end
        READ_B: begin
          op_b_q  <= fetched;
          state_q <= HOLD;
        end
        HOLD: begin
          // The consuming edge returns to IDLE; a write-back on that edge is not merged.
          if (op_ready) begin
            state_q <= IDLE;
          end else begin
            if (hit_a) op_a_q <= wb_data;
            if (hit_b) op_b_q <= wb_data;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign op_valid  = (state_q == HOLD);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus randomized transactions against
// a register-file model and an edge-by-edge operand expectation.
module tb_operand_fetch;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b1;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_rs1;
  logic [AW-1:0] req_rs2;
  logic          req_use_rs2;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          op_valid;
  logic          op_ready;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;

  logic [DW-1:0] regs [32];
  logic          force_rd;
  logic [DW-1:0] force_val;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  operand_fetch #(.data_width(DW), .addr_width(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_use_rs2 (req_use_rs2),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_a        (op_a),
    .op_b        (op_b)
  );

  initial forever #5 clk = ~clk;

  // Register file model: combinational read, write on the falling edge.
  assign rd_data = force_rd ? force_val : regs[rd_addr];
  always @(negedge clk) if (wb_en) regs[wb_addr] <= wb_data;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change in the high phase, the design updates on the falling edge,
  // outputs are sampled at the following rising edge.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic set_wb(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_en = en; wb_addr = a; wb_data = d;
  endtask

  task automatic rand_wb();
    set_wb(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
  endtask

  task automatic accept(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic use2);
    req_rs1 = r1; req_rs2 = r2; req_use_rs2 = use2; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, DW'(req_ready), DW'(1'b1));
    chk({tag, "_valid"}, DW'(op_valid), DW'(1'b0));
    chk({tag, "_rdaddr"}, DW'(rd_addr), DW'(0));
  endtask

  // Value a read of register a returns on the coming edge.
  function automatic logic [DW-1:0] fetch_ref(input logic [AW-1:0] a);
    if (a == AW'(0)) return '0;
    if (wb_en && wb_addr == a) return wb_data;
    return force_rd ? force_val : regs[a];
  endfunction

  task automatic rand_txn();
    logic [AW-1:0] r1, r2;
    logic          use2, consume;
    logic [DW-1:0] exp_a, exp_b;
    r1 = AW'($urandom_range(0, 7));
    r2 = AW'($urandom_range(0, 7));
    use2 = 1'($urandom_range(0, 1));
    req_rs1 = r1; req_rs2 = r2; req_use_rs2 = use2; req_valid = 1'b1;
    rand_wb();
    tick();
    chk("rt_a_rdaddr", DW'(rd_addr), DW'(r1));
    chk("rt_a_valid", DW'(op_valid), DW'(1'b0));
    chk("rt_a_ready", DW'(req_ready), DW'(1'b0));
    // Junk requests while busy must be ignored.
    req_valid = 1'($urandom_range(0, 1));
    req_rs1 = AW'($urandom); req_rs2 = AW'($urandom); req_use_rs2 = 1'($urandom);
    rand_wb();
    exp_a = fetch_ref(r1);
    tick();
    exp_b = '0;
    if (use2) begin
      chk("rt_b_rdaddr", DW'(rd_addr), DW'(r2));
      chk("rt_b_valid", DW'(op_valid), DW'(1'b0));
      rand_wb();
      exp_b = fetch_ref(r2);
      tick();
    end
    for (int c = 0; c < 8; c++) begin
      chk("rt_h_valid", DW'(op_valid), DW'(1'b1));
      chk("rt_h_ready", DW'(req_ready), DW'(1'b0));
      chk("rt_h_rdaddr", DW'(rd_addr), DW'(0));
      chk("rt_h_op_a", op_a, exp_a);
      chk("rt_h_op_b", op_b, exp_b);
      consume = (c == 7) ? 1'b1 : ($urandom_range(0, 2) == 0);
      op_ready = consume;
      rand_wb();
      if (!consume && wb_en && wb_addr != AW'(0)) begin
        if (wb_addr == r1) exp_a = wb_data;
        if (use2 && wb_addr == r2) exp_b = wb_data;
      end
      tick();
      if (consume) break;
    end
    op_ready = 1'b0;
    req_valid = 1'b0;
    set_wb(1'b0, '0, '0);
    chk_idle("rt_done");
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_use_rs2 = 1'b0;
    op_ready = 1'b0; force_rd = 1'b0; force_val = '0;
    set_wb(1'b0, '0, '0);

    // Load every register (including r0, which must still read as zero) under reset.
    for (int r = 0; r < 32; r++) begin
      set_wb(1'b1, AW'(r), $urandom | 32'h1);
      tick();
    end
    set_wb(1'b0, '0, '0);
    chk_idle("rst");
    chk("rst_op_a", op_a, '0);
    chk("rst_op_b", op_b, '0);
    reset = 1'b0;
    tick();
    chk_idle("post_rst");

    // Reset during READ_B aborts with no partial output.
    accept(5'd3, 5'd4, 1'b1);
    tick();
    chk("midb_rdaddr", DW'(rd_addr), DW'(4));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("midb_rst");
    chk("midb_op_a", op_a, '0);
    chk("midb_op_b", op_b, '0);
    tick();
    chk_idle("midb_after");

    // Two-register read.
    set_wb(1'b1, 5'd3, 32'h11); tick();
    set_wb(1'b1, 5'd4, 32'h22); tick();
    set_wb(1'b0, '0, '0);
    accept(5'd3, 5'd4, 1'b1);
    chk("two_ready", DW'(req_ready), DW'(1'b0));
    chk("two_a_rdaddr", DW'(rd_addr), DW'(3));
    chk("two_a_valid", DW'(op_valid), DW'(1'b0));
    tick();
    chk("two_b_rdaddr", DW'(rd_addr), DW'(4));
    chk("two_b_valid", DW'(op_valid), DW'(1'b0));
    tick();
    chk("two_valid", DW'(op_valid), DW'(1'b1));
    chk("two_op_a", op_a, 32'h11);
    chk("two_op_b", op_b, 32'h22);
    op_ready = 1'b1; tick(); op_ready = 1'b0;
    chk_idle("two_done");

    // Immediate form from r0 with the read port driven all ones.
    force_rd = 1'b1; force_val = 32'hFFFF_FFFF;
    accept(5'd0, 5'd4, 1'b0);
    chk("imm0_valid0", DW'(op_valid), DW'(1'b0));
    tick();
    chk("imm0_valid", DW'(op_valid), DW'(1'b1));
    chk("imm0_op_a", op_a, '0);
    chk("imm0_op_b", op_b, '0);
    op_ready = 1'b1; tick(); op_ready = 1'b0;
    chk_idle("imm0_done");

    // Forwarding of a same-edge write-back during READ_A.
    force_val = 32'h1;
    accept(5'd5, 5'd0, 1'b0);
    chk("fwd_rdaddr", DW'(rd_addr), DW'(5));
    set_wb(1'b1, 5'd5, 32'hA5);
    tick();
    set_wb(1'b0, '0, '0);
    force_rd = 1'b0;
    chk("fwd_valid", DW'(op_valid), DW'(1'b1));
    chk("fwd_op_a", op_a, 32'hA5);
    op_ready = 1'b1; tick(); op_ready = 1'b0;

    // Coherence in HOLD with rs1 == rs2.
    accept(5'd7, 5'd7, 1'b1);
    tick(); tick();
    chk("coh_valid", DW'(op_valid), DW'(1'b1));
    set_wb(1'b1, 5'd7, 32'h3C); tick();
    chk("coh_op_a", op_a, 32'h3C);
    chk("coh_op_b", op_b, 32'h3C);
    set_wb(1'b1, 5'd0, 32'h55); tick();
    chk("coh_r0_op_a", op_a, 32'h3C);
    chk("coh_r0_op_b", op_b, 32'h3C);
    // Write-back on the consuming edge is not merged.
    set_wb(1'b1, 5'd7, 32'h99); op_ready = 1'b1; tick();
    op_ready = 1'b0; set_wb(1'b0, '0, '0);
    chk_idle("coh_done");
    chk("coh_lost_a", op_a, 32'h3C);

    // Back-to-back two-register requests: one acceptance every fourth edge.
    req_rs1 = 5'd1; req_rs2 = 5'd2; req_use_rs2 = 1'b1; req_valid = 1'b1; op_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("b2b_ready", DW'(req_ready), DW'(i % 4 == 0));
      chk("b2b_valid", DW'(op_valid), DW'(i % 4 == 3));
      tick();
    end
    req_valid = 1'b0; op_ready = 1'b0;
    chk_idle("b2b_done");

    for (int t = 0; t < 60; t++) rand_txn();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
